// File: rtl/nixie_scanner.sv
// Multiplexed hex driver for a common-anode seven-segment bank: shadow-latched digits, dp, lz blanking, blink.
// Latency: shadow written on the load edge, visible on seg_n/sel_n from the next edge; outputs registered.
// Backpressure: none; load is a one-cycle strobe that is always accepted, scanning is free-running.
module nixie_scanner #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     sel_n
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] LAST_BLK = BW'(BLINK_DIV - 1);

  // Shadow copy of the display register; the scanner never looks at the live inputs
  logic [DIGITS-1:0][3:0] r_data;
  logic [DIGITS-1:0]      r_dp;
  logic [DIGITS-1:0]      r_blink;

  logic [PW-1:0]          r_pre;
  logic [IW-1:0]          r_idx;
  logic [BW-1:0]          r_bcnt;
  logic                   r_phase;

  logic [7:0]             r_seg_n;
  logic [DIGITS-1:0]      r_sel_n;

  logic [DIGITS-1:0]      w_tail_zero;
  logic [3:0]             w_nib;
  logic                   w_dp_bit;
  logic [7:0]             w_seg_n;
  logic [DIGITS-1:0]      w_sel_n;

  // Raw active-high segment pattern, a..g in bits 6..0
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] c;
    case (nib)
      4'h0: c = 7'h7E;
      4'h1: c = 7'h30;
      4'h2: c = 7'h6D;
      4'h3: c = 7'h79;
      4'h4: c = 7'h33;
      4'h5: c = 7'h5B;
      4'h6: c = 7'h5F;
      4'h7: c = 7'h70;
      4'h8: c = 7'h7F;
      4'h9: c = 7'h7B;
      4'hA: c = 7'h7D;
      4'hB: c = 7'h1F;
      4'hC: c = 7'h0D;
      4'hD: c = 7'h3D;
      4'hE: c = 7'h6F;
      default: c = 7'h47;
    endcase
    return c;
  endfunction

  // w_tail_zero[i] is set when digit i and every more significant digit hold zero
  always_comb begin
    w_tail_zero = '1;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = 0; j < DIGITS; j++) begin
        if (j >= i && r_data[j] != 4'h0) begin
          w_tail_zero[i] = 1'b0;
        end
      end
    end
  end

  assign w_nib    = r_data[r_idx];
  assign w_dp_bit = r_dp[r_idx];
  assign w_sel_n  = ~(DIGITS'(1) << r_idx);

  // Pattern for the digit currently selected; blink blanks everything, lz blanking keeps the dp
  always_comb begin
    w_seg_n = ~{w_dp_bit, seg_code(w_nib)};
    if (r_phase && r_blink[r_idx]) begin
      w_seg_n = 8'hFF;
    end else if (lz_en && (r_idx != '0) && w_tail_zero[r_idx]) begin
      w_seg_n = ~{w_dp_bit, 7'h00};
    end
  end

  // Shadow capture, scan prescaler/index, blink timebase and registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_dp    <= '0;
      r_blink <= '0;
      r_pre   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_seg_n <= 8'hFF;
      r_sel_n <= '1;
    end else begin
      if (load) begin
        r_data  <= data;
        r_dp    <= dp;
        r_blink <= blink;
      end

      if (r_pre == LAST_PRE) begin
        r_pre <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      if (r_bcnt == LAST_BLK) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end

      r_seg_n <= w_seg_n;
      r_sel_n <= w_sel_n;
    end
  end

  assign seg_n = r_seg_n;
  assign sel_n = r_sel_n;

endmodule

// File: tb/tb_nixie_scanner.sv
// Directed bench for nixie_scanner with DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
// Inputs change and outputs are sampled on the falling edge; "edge n" is the n-th rising edge after reset release.
// Expected segment codes are hand-derived from the active-high table, inverted.
module tb_nixie_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic        lz_en;
  logic        load;
  logic [7:0]  seg_n;
  logic [3:0]  sel_n;

  int n_cmp;
  int n_fail;

  logic [7:0] dec_exp [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                               8'h80, 8'h84, 8'h82, 8'hE0, 8'hF2, 8'hC2, 8'h90, 8'hB8};
  logic [3:0] sel_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] frame_1234 [4] = '{8'hCC, 8'h86, 8'h92, 8'hCF};
  logic [7:0] frame_lz   [4] = '{8'h81, 8'hA4, 8'hFF, 8'hFF};
  logic [7:0] frame_nolz [4] = '{8'h81, 8'hA4, 8'h81, 8'h81};
  logic [7:0] frame_zdp  [4] = '{8'h81, 8'hFF, 8'h7F, 8'hFF};
  logic [7:0] frame_bl1  [4] = '{8'hCF, 8'hCF, 8'hFF, 8'hCF};
  logic [7:0] frame_bl2  [4] = '{8'hCF, 8'hCF, 8'hFF, 8'hFF};

  nixie_scanner #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .BLINK_DIV(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .dp   (dp),
    .blink(blink),
    .lz_en(lz_en),
    .load (load),
    .seg_n(seg_n),
    .sel_n(sel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] exp_seg, input logic [3:0] exp_sel);
    n_cmp++;
    assert (seg_n === exp_seg) else begin
      n_fail++;
      $error("FAIL %s: seg_n observed %h expected %h", tag, seg_n, exp_seg);
    end
    n_cmp++;
    assert (sel_n === exp_sel) else begin
      n_fail++;
      $error("FAIL %s: sel_n observed %b expected %b", tag, sel_n, exp_sel);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    data  = 16'h0000;
    dp    = 4'b0000;
    blink = 4'b0000;
    lz_en = 1'b0;
    step();
    check("reset_state", 8'hFF, 4'b1111);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Basic scan of 1234
    do_reset();
    data = 16'h1234;
    load = 1'b1;
    step();
    check("scan_edge1_old_shadow", 8'h81, 4'b1110);
    load = 1'b0;
    for (int e = 2; e <= 17; e++) begin
      step();
      check("scan_1234", frame_1234[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end

    // Decoder sweep on digit 0
    for (int n = 0; n < 16; n++) begin
      do_reset();
      data = 16'(n);
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      check("decode", dec_exp[n], 4'b1110);
    end
    do_reset();
    data = 16'h0008;
    dp   = 4'b0001;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("decode_8_dp", 8'h00, 4'b1110);

    // Leading-zero suppression, then lz off (level-sensitive), then all zero with a dp
    do_reset();
    data  = 16'h0050;
    lz_en = 1'b1;
    load  = 1'b1;
    step();
    load = 1'b0;
    for (int e = 2; e <= 16; e++) begin
      step();
      check("lz_0050", frame_lz[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end
    lz_en = 1'b0;
    for (int e = 17; e <= 32; e++) begin
      step();
      check("lz_off_0050", frame_nolz[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end
    lz_en = 1'b1;
    data  = 16'h0000;
    dp    = 4'b0100;
    load  = 1'b1;
    step();
    check("lz_zero_edge33", 8'h81, 4'b1110);
    load = 1'b0;
    for (int e = 34; e <= 48; e++) begin
      step();
      check("lz_zero_dp", frame_zdp[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end

    // Blink: phase 0 on edges 1..8, phase 1 on 9..16, phase 0 on 17..24, phase 1 on 25..32
    do_reset();
    data  = 16'h1111;
    blink = 4'b0101;
    load  = 1'b1;
    step();
    load = 1'b0;
    for (int e = 2; e <= 15; e++) begin
      step();
      check("blink_0101", frame_bl1[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end
    blink = 4'b1111;
    load  = 1'b1;
    step();
    check("blink_edge16", 8'hCF, 4'b0111);
    load = 1'b0;
    for (int e = 17; e <= 32; e++) begin
      step();
      check("blink_1111", frame_bl2[((e - 1) / 4) % 4], sel_exp[((e - 1) / 4) % 4]);
    end

    // Load in the middle of digit 1 dwell (edges 5..8)
    do_reset();
    data = 16'h1111;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      step();
    end
    check("midload_edge5", 8'hCF, 4'b1101);
    data = 16'hAAAA;
    load = 1'b1;
    step();
    check("midload_edge6_old", 8'hCF, 4'b1101);
    load = 1'b0;
    step();
    check("midload_edge7_new", 8'h82, 4'b1101);
    step();
    check("midload_edge8", 8'h82, 4'b1101);
    step();
    check("midload_edge9_next", 8'h82, 4'b1011);

    // Reset mid-frame together with load: the load must be ignored
    reset = 1'b1;
    data  = 16'h1234;
    dp    = 4'b1111;
    blink = 4'b0000;
    load  = 1'b1;
    step();
    check("reset_with_load", 8'hFF, 4'b1111);
    step();
    check("reset_held", 8'hFF, 4'b1111);
    reset = 1'b0;
    data  = 16'h1111;
    dp    = 4'b0000;
    step();
    check("post_reset_edge1", 8'h81, 4'b1110);
    data = 16'h5555;
    step();
    check("b2b_edge2", 8'hCF, 4'b1110);
    load = 1'b0;
    step();
    check("b2b_edge3_last_wins", 8'hA4, 4'b1110);
    step();
    check("b2b_edge4", 8'hA4, 4'b1110);
    step();
    check("b2b_edge5_digit1", 8'hA4, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
